wb_port_rr_arbiter: RTL

- Round-robin arbiter that shares one 32-bit datapath port between 4 requesters, e.g. the writeback/memory bus fed by the 32-bit 4-to-1 select mux.
- Produces the mux 2-bit select, a one-hot grant and a bus valid, and counts completed beats against a consumer ready.
- Bounds how long one owner holds the port while others wait.
- Sits between the pipeline stage requesters and the shared port consumer; contains no data path itself.

---
 rtl/wb_port_rr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wb_port_rr_arbiter.sv
// Round-robin arbiter for one shared 32-bit port across 4 requesters, bounding hold time per grant.
// Optional macro ARB_URGENT_EN adds an urgent[3:0] input that takes priority and forces early handover.
module wb_port_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] req,
`ifdef ARB_URGENT_EN
    input  logic [3:0] urgent,
`endif
    input  logic       bus_ready,
    output logic [3:0] grant,
    output logic [1:0] select_signal,
    output logic       bus_valid,
    output logic       beat_done
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [3:0]       grant_n;
    logic [1:0]       select_n;
    logic [1:0]       rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_n;

    logic [3:0]       urg;
    logic [3:0]       owner_oh;
    logic [3:0]       others;
    logic             urgent_other;
    logic             withdraw;
    logic             release_now;
    logic [1:0]       scan_ptr;
    logic [2:0]       pick;

`ifdef ARB_URGENT_EN
    assign urg = urgent;
`else
    assign urg = '0;
`endif

    // Returns {found, index} of the first set bit of r scanning ptr, ptr+1, ... mod 4.
    function automatic logic [2:0] rr_scan(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [3:0] u,
                                             input logic [1:0] ptr);
        logic [2:0] hi;
        hi = rr_scan(r & u, ptr);
        return hi[2] ? hi : rr_scan(r, ptr);
    endfunction

    assign bus_valid = (|grant) && req[select_signal];
    assign beat_done = bus_valid && bus_ready;

    always_comb begin
        owner_oh     = 4'b0001 << select_signal;
        others       = req & ~owner_oh;
        urgent_other = |(others & urg);
        withdraw     = (state == GRANT) && !req[select_signal];
        // A hold-limit release only happens on a completed beat, so grant never moves under backpressure.
        release_now  = withdraw ||
                       (beat_done && (|others) && ((beat_cnt == HOLD_LAST) || urgent_other));
        scan_ptr     = release_now ? select_signal + 2'd1 : rr_ptr;
        pick         = arbitrate(req, urg, scan_ptr);
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        select_n   = select_signal;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        case (state)
            IDLE: begin
                if (pick[2]) begin
                    state_n    = GRANT;
                    grant_n    = 4'b0001 << pick[1:0];
                    select_n   = pick[1:0];
                    beat_cnt_n = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    rr_ptr_n = select_signal + 2'd1;
                    if (pick[2]) begin
                        grant_n    = 4'b0001 << pick[1:0];
                        select_n   = pick[1:0];
                        beat_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end else if (beat_done && (beat_cnt != HOLD_LAST)) begin
                    beat_cnt_n = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            grant         <= '0;
            select_signal <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            select_signal <= select_n;
            rr_ptr        <= rr_ptr_n;
            beat_cnt      <= beat_cnt_n;
        end
    end

endmodule
